// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALUOp and forward-select encodings plus the control bundle
// that rides down the ID/EX, EX/MEM and MEM/WB registers.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // The younger producer (EX/MEM) wins over MEM/WB when both match.
  function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)      return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage opcode decoder: control bundle, source-register use
// flags and an illegal-opcode indication.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RFUNCT;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_I: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_IFUNCT;
        use_rs1        = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        use_rs1         = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_JAL: begin
        if (EXT_OPS != 0) begin
          ctrl.reg_write = 1'b1;
          ctrl.link      = 1'b1;
          ctrl.jump      = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (EXT_OPS != 0) begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.link      = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.alu_op    = ALU_ADD;
          use_rs1        = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decodes in ID, carries control through EX/MEM/WB,
// detects load-use hazards, selects EX forwarding and counts stalls/flushes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2,
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        Op_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              cmp_true_i,
  input  logic              mem_stall_i,
  output logic [ALUOP_W-1:0] ex_ALUOp_o,
  output logic              ex_ALUSrc_o,
  output logic [1:0]        fwdA_o,
  output logic [1:0]        fwdB_o,
  output logic              mem_MemRead_o,
  output logic              mem_MemWrite_o,
  output logic              wb_RegWrite_o,
  output logic              wb_MemtoReg_o,
  output logic              wb_Link_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t             id_ctrl;
  logic              id_use_rs1;
  logic              id_use_rs2;

  ctrl_t             ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;

  logic              hazard;
  logic              taken;
  logic              front_go;

  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .op      (Op_i),
    .ctrl    (id_ctrl),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .illegal (illegal_o)
  );

  always_comb begin
    hazard = ex_ctrl.mem_read && (ex_rd != '0) &&
             ((id_use_rs1 && (ex_rd == rs1_i)) || (id_use_rs2 && (ex_rd == rs2_i)));
    taken  = (id_ctrl.branch & cmp_true_i) | id_ctrl.jump;
  end

  // Front end only moves when out of reset, not frozen, and not bubbling.
  assign front_go     = rst_i & ~mem_stall_i & ~hazard;
  assign pc_write_o   = front_go;
  assign ifid_write_o = front_go;
  assign ifid_flush_o = front_go & taken;

  assign fwdA_o = fwd_sel(mem_ctrl.reg_write && (mem_rd != '0) && (mem_rd == ex_rs1),
                          wb_ctrl.reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs1));
  assign fwdB_o = fwd_sel(mem_ctrl.reg_write && (mem_rd != '0) && (mem_rd == ex_rs2),
                          wb_ctrl.reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs2));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_ctrl     <= CTRL_NOP;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      mem_ctrl    <= CTRL_NOP;
      mem_rd      <= '0;
      wb_ctrl     <= CTRL_NOP;
      wb_rd       <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!mem_stall_i) begin
        if (hazard) begin
          ex_ctrl <= CTRL_NOP;
          ex_rd   <= '0;
          ex_rs1  <= '0;
          ex_rs2  <= '0;
        end else begin
          ex_ctrl <= id_ctrl;
          ex_rd   <= rd_i;
          ex_rs1  <= rs1_i;
          ex_rs2  <= rs2_i;
        end
        mem_ctrl <= ex_ctrl;
        mem_rd   <= ex_rd;
        wb_ctrl  <= mem_ctrl;
        wb_rd    <= mem_rd;
      end
      if ((mem_stall_i || hazard) && (stall_cnt_o != CNT_MAX))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_o != CNT_MAX))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

  assign ex_ALUOp_o     = ALUOP_W'(ex_ctrl.alu_op);
  assign ex_ALUSrc_o    = ex_ctrl.alu_src;
  assign mem_MemRead_o  = mem_ctrl.mem_read;
  assign mem_MemWrite_o = mem_ctrl.mem_write;
  assign wb_RegWrite_o  = wb_ctrl.reg_write;
  assign wb_MemtoReg_o  = wb_ctrl.mem_to_reg;
  assign wb_Link_o      = wb_ctrl.link;
  assign wb_rd_o        = wb_rd;

  // Control bits that have no consumer once the instruction reaches WB.
  logic unused_wb_bits;
  assign unused_wb_bits = ^{wb_ctrl.alu_op, wb_ctrl.alu_src, wb_ctrl.branch,
                            wb_ctrl.jump, wb_ctrl.mem_read, wb_ctrl.mem_write};

endmodule
